// File: rtl/warp_scheduler_mp_pkg.sv
// Shared GPU core definitions: warp status, scheduling policies and
// core-wide widths used by the warp scheduler and its neighbours.
package pkg_opengpu;

    localparam int DATA_WIDTH       = 32;
    localparam int WARP_SIZE        = 32;
    localparam int WARPS_PER_CORE   = 4;
    localparam int WARP_ID_WIDTH    = $clog2(WARPS_PER_CORE);
    localparam int SCHED_MAX_GREEDY = 16;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_READY   = 3'd1,
        WARP_RUNNING = 3'd2,
        WARP_WAITING = 3'd3,
        WARP_BLOCKED = 3'd4,
        WARP_DONE    = 3'd5
    } warp_status_e;

    typedef enum logic [1:0] {
        SCHED_GTO    = 2'd0,
        SCHED_LRR    = 2'd1,
        SCHED_OLDEST = 2'd2
    } sched_mode_e;

endpackage

// File: rtl/warp_scheduler_mp_arbiter.sv
// Oldest-request finder: largest age wins, equal ages go to the lowest id.
module warp_age_arbiter #(
    parameter int NUM_WARPS = 4,
    parameter int AGE_WIDTH = 8,
    parameter int ID_W      = 2
) (
    input  logic [NUM_WARPS-1:0]           req,
    input  logic [NUM_WARPS*AGE_WIDTH-1:0] age,
    output logic                           found,
    output logic [ID_W-1:0]                id
);

    logic [AGE_WIDTH-1:0] best;

    always_comb begin
        found = 1'b0;
        id    = '0;
        best  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (req[w] && (!found || age[w*AGE_WIDTH +: AGE_WIDTH] > best)) begin
                found = 1'b1;
                id    = ID_W'(w);
                best  = age[w*AGE_WIDTH +: AGE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/warp_scheduler_mp.sv
// Multi-policy warp scheduler (GTO / LRR / oldest-first) with a registered
// selection, valid/ready issue port and a greedy-run cap.
module warp_scheduler_mp
    import pkg_opengpu::*;
#(
    parameter int NUM_WARPS    = WARPS_PER_CORE,
    parameter int AGE_WIDTH    = 8,
    parameter int MAX_GREEDY   = SCHED_MAX_GREEDY,
    parameter int GREEDY_CNT_W = $clog2(MAX_GREEDY + 1),
    parameter int ID_W         = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [1:0]                      sched_mode,
    input  logic [NUM_WARPS*DATA_WIDTH-1:0] ctx_pc,
    input  logic [NUM_WARPS*WARP_SIZE-1:0]  ctx_mask,
    input  logic [NUM_WARPS*3-1:0]          ctx_status,
    input  logic [NUM_WARPS*AGE_WIDTH-1:0]  ctx_age,
    input  logic [NUM_WARPS-1:0]            ctx_valid,
    input  logic [NUM_WARPS-1:0]            warp_stall,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [ID_W-1:0]                 issue_warp_id,
    output logic [DATA_WIDTH-1:0]           issue_pc,
    output logic [WARP_SIZE-1:0]            issue_mask,
    output logic                            all_done
);

    localparam logic [GREEDY_CNT_W-1:0] CNT_MAX = GREEDY_CNT_W'(MAX_GREEDY);

    logic                    sel_valid_q, sel_valid_d;
    logic [ID_W-1:0]         sel_id_q, sel_id_d;
    logic                    last_valid_q, last_valid_d;
    logic [ID_W-1:0]         last_id_q, last_id_d;
    logic [GREEDY_CNT_W-1:0] greedy_cnt_q, greedy_cnt_d;

    logic [NUM_WARPS-1:0]    eligible, done_vec, last_oh, others, arb_req;
    logic                    sel_elig, fire, reload, cap_hit, last_elig;
    logic                    pend_last_valid;
    logic [ID_W-1:0]         pend_last_id;
    logic [GREEDY_CNT_W-1:0] pend_cnt;
    logic                    arb_found, lrr_found, cand_found;
    logic [ID_W-1:0]         arb_id, lrr_id, cand_id;
    int                      lrr_start, lrr_idx;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            eligible[w] = ctx_valid[w] && !warp_stall[w]
                       && ctx_status[w*3 +: 3] == WARP_READY;
            done_vec[w] = !ctx_valid[w] || ctx_status[w*3 +: 3] == WARP_DONE;
        end
    end

    assign all_done      = &done_vec;
    assign sel_elig      = eligible[sel_id_q];
    assign issue_valid   = sel_valid_q && sel_elig;
    assign fire          = issue_valid && issue_ready;
    assign issue_warp_id = sel_id_q;
    assign issue_pc      = ctx_pc[int'(sel_id_q)*DATA_WIDTH +: DATA_WIDTH];
    assign issue_mask    = ctx_mask[int'(sel_id_q)*WARP_SIZE +: WARP_SIZE];

    // Last-issue state as it will be after this cycle's fire; the next
    // candidate is chosen against it so back-to-back picks stay correct.
    always_comb begin
        pend_last_valid = last_valid_q;
        pend_last_id    = last_id_q;
        pend_cnt        = greedy_cnt_q;
        if (fire) begin
            pend_last_valid = 1'b1;
            pend_last_id    = sel_id_q;
            if (last_valid_q && sel_id_q == last_id_q)
                pend_cnt = (greedy_cnt_q == CNT_MAX) ? CNT_MAX : greedy_cnt_q + 1'b1;
            else
                pend_cnt = GREEDY_CNT_W'(1);
        end
    end

    always_comb begin
        last_oh               = '0;
        last_oh[pend_last_id] = 1'b1;
        cap_hit   = pend_last_valid && pend_cnt == CNT_MAX;
        last_elig = pend_last_valid && eligible[pend_last_id];
        others    = eligible & ~last_oh;
        arb_req   = (cap_hit && |others) ? others : eligible;
    end

    warp_age_arbiter #(
        .NUM_WARPS (NUM_WARPS),
        .AGE_WIDTH (AGE_WIDTH),
        .ID_W      (ID_W)
    ) u_age_arb (
        .req   (arb_req),
        .age   (ctx_age),
        .found (arb_found),
        .id    (arb_id)
    );

    always_comb begin
        lrr_found = 1'b0;
        lrr_id    = '0;
        lrr_idx   = 0;
        lrr_start = 0;
        if (pend_last_valid && int'(pend_last_id) < NUM_WARPS - 1)
            lrr_start = int'(pend_last_id) + 1;
        for (int k = 0; k < NUM_WARPS; k++) begin
            lrr_idx = lrr_start + k;
            if (lrr_idx >= NUM_WARPS)
                lrr_idx = lrr_idx - NUM_WARPS;
            if (!lrr_found && eligible[lrr_idx]) begin
                lrr_found = 1'b1;
                lrr_id    = ID_W'(lrr_idx);
            end
        end
    end

    always_comb begin
        cand_found = arb_found;
        cand_id    = arb_id;
        case (sched_mode)
            SCHED_LRR: begin
                cand_found = lrr_found;
                cand_id    = lrr_id;
            end
            SCHED_OLDEST: ;
            default: begin
                if (last_elig && !cap_hit) begin
                    cand_found = 1'b1;
                    cand_id    = pend_last_id;
                end
            end
        endcase
    end

    always_comb begin
        reload       = !sel_valid_q || fire || !sel_elig;
        sel_valid_d  = reload ? cand_found : sel_valid_q;
        sel_id_d     = reload ? cand_id : sel_id_q;
        last_valid_d = pend_last_valid;
        last_id_d    = pend_last_id;
        greedy_cnt_d = pend_cnt;
        if (flush) begin
            sel_valid_d  = 1'b0;
            sel_id_d     = sel_id_q;
            last_valid_d = 1'b0;
            last_id_d    = last_id_q;
            greedy_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_valid_q  <= 1'b0;
            sel_id_q     <= '0;
            last_valid_q <= 1'b0;
            last_id_q    <= '0;
            greedy_cnt_q <= '0;
        end else begin
            sel_valid_q  <= sel_valid_d;
            sel_id_q     <= sel_id_d;
            last_valid_q <= last_valid_d;
            last_id_q    <= last_id_d;
            greedy_cnt_q <= greedy_cnt_d;
        end
    end

endmodule

// File: tb/tb_warp_scheduler_mp.sv
// Bench for warp_scheduler_mp: directed corners, a vector table and
// randomized segments checked against a policy-level reference model.
module tb_warp_scheduler_mp;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int WS = 32;
    localparam int AW = 8;
    localparam int MG = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [1:0]      sched_mode;
    logic [N*DW-1:0] ctx_pc;
    logic [N*WS-1:0] ctx_mask;
    logic [N*3-1:0]  ctx_status;
    logic [N*AW-1:0] ctx_age;
    logic [N-1:0]    ctx_valid;
    logic [N-1:0]    warp_stall;
    logic            issue_valid;
    logic            issue_ready;
    logic [1:0]      issue_warp_id;
    logic [DW-1:0]   issue_pc;
    logic [WS-1:0]   issue_mask;
    logic            all_done;

    warp_scheduler_mp #(.NUM_WARPS(N), .AGE_WIDTH(AW), .MAX_GREEDY(MG)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .sched_mode    (sched_mode),
        .ctx_pc        (ctx_pc),
        .ctx_mask      (ctx_mask),
        .ctx_status    (ctx_status),
        .ctx_age       (ctx_age),
        .ctx_valid     (ctx_valid),
        .warp_stall    (warp_stall),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_warp_id (issue_warp_id),
        .issue_pc      (issue_pc),
        .issue_mask    (issue_mask),
        .all_done      (all_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int fired[$];

    bit m_sel_valid, m_last_valid;
    int m_sel_id, m_last_id, m_cnt;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic bit m_elig(int w);
        return ctx_valid[w] && !warp_stall[w] && ctx_status[w*3 +: 3] == 3'd1;
    endfunction

    function automatic bit m_all_done();
        for (int w = 0; w < N; w++)
            if (ctx_valid[w] && ctx_status[w*3 +: 3] != 3'd5) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_oldest(int skip);
        int best = -1;
        for (int w = 0; w < N; w++)
            if (m_elig(w) && w != skip)
                if (best < 0 || ctx_age[w*AW +: AW] > ctx_age[best*AW +: AW]) best = w;
        return best;
    endfunction

    function automatic int m_pick(int lid, bit lv, int cnt);
        int n = 0;
        bit capped;
        for (int w = 0; w < N; w++) n += m_elig(w);
        if (n == 0) return -1;
        if (sched_mode == 2'd1) begin
            for (int k = 0; k < N; k++)
                if (m_elig(((lv ? lid + 1 : 0) + k) % N)) return ((lv ? lid + 1 : 0) + k) % N;
        end
        capped = lv && cnt >= MG;
        if (sched_mode != 2'd2 && lv && m_elig(lid) && !capped) return lid;
        if (capped && m_oldest(lid) >= 0) return m_oldest(lid);
        return m_oldest(-1);
    endfunction

    task automatic m_reset();
        m_sel_valid = 0; m_sel_id = 0; m_last_valid = 0; m_last_id = 0; m_cnt = 0;
    endtask

    // Check outputs against the model, then advance model and DUT one clock.
    task automatic cycle();
        bit iv, fire, nsv, nlv;
        int nsid, nlid, ncnt, p;
        #1;
        iv = m_sel_valid && m_elig(m_sel_id);
        chk("issue_valid", issue_valid, iv);
        if (iv) begin
            chk("issue_warp_id", issue_warp_id, m_sel_id);
            chk("issue_pc", issue_pc, ctx_pc[m_sel_id*DW +: DW]);
            chk("issue_mask", issue_mask, ctx_mask[m_sel_id*WS +: WS]);
        end
        chk("all_done", all_done, m_all_done());
        if (issue_valid && issue_ready) fired.push_back(int'(issue_warp_id));
        fire = iv && issue_ready;
        nsv = m_sel_valid; nsid = m_sel_id;
        nlv = m_last_valid; nlid = m_last_id; ncnt = m_cnt;
        if (flush) begin
            nsv = 0; nlv = 0; ncnt = 0;
        end else begin
            if (fire) begin
                ncnt = (m_last_valid && m_sel_id == m_last_id) ?
                       ((m_cnt < MG) ? m_cnt + 1 : MG) : 1;
                nlid = m_sel_id;
                nlv = 1;
            end
            if (!m_sel_valid || fire || !m_elig(m_sel_id)) begin
                p = m_pick(nlid, nlv, ncnt);
                nsv = (p >= 0);
                if (p >= 0) nsid = p;
            end
        end
        @(posedge clk);
        #1;
        m_sel_valid = nsv; m_sel_id = nsid;
        m_last_valid = nlv; m_last_id = nlid; m_cnt = ncnt;
    endtask

    task automatic set_warp(int w, bit v, logic [2:0] st, int age, int pc);
        ctx_valid[w] = v;
        ctx_status[w*3 +: 3] = st;
        ctx_age[w*AW +: AW] = AW'(age);
        ctx_pc[w*DW +: DW] = DW'(pc);
        ctx_mask[w*WS +: WS] = WS'(32'hF0F0_0000 | pc);
    endtask

    task automatic gto_ages();
        set_warp(0, 1, 3'd1, 5, 'h200);
        set_warp(1, 1, 3'd1, 10, 'h300);
        set_warp(2, 1, 3'd1, 3, 'h400);
        set_warp(3, 1, 3'd1, 7, 'h500);
    endtask

    task automatic do_flush();
        flush = 1;
        cycle();
        flush = 0;
        fired.delete();
    endtask

    task automatic run_fires(int n);
        for (int i = 0; i < 80 && fired.size() < n; i++) cycle();
        chk("fire_budget", fired.size() >= n, 1);
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [11:0] status;
        logic [3:0]  stall;
        logic        exp_done;
        logic        exp_any;
    } vec_t;

    vec_t vecs[8];
    int exp_q[$];

    initial begin
        vecs[0] = '{4'b0000, 12'h249, 4'b0000, 1'b1, 1'b0};
        vecs[1] = '{4'b1111, 12'hB6D, 4'b0000, 1'b1, 1'b0};
        vecs[2] = '{4'b1111, 12'hB6C, 4'b0000, 1'b0, 1'b0};
        vecs[3] = '{4'b0111, 12'h36D, 4'b0000, 1'b1, 1'b0};
        vecs[4] = '{4'b1111, 12'h249, 4'b1111, 1'b0, 1'b0};
        vecs[5] = '{4'b1111, 12'h249, 4'b1011, 1'b0, 1'b1};
        vecs[6] = '{4'b1010, 12'h249, 4'b0000, 1'b0, 1'b1};
        vecs[7] = '{4'b1111, 12'hAED, 4'b0000, 1'b0, 1'b0};

        rst_n = 0; flush = 0; sched_mode = 0; issue_ready = 0;
        ctx_pc = '0; ctx_mask = '0; ctx_status = '0; ctx_age = '0;
        ctx_valid = '0; warp_stall = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_all_done", all_done, 1);
        chk("rst_warp_id", issue_warp_id, 0);
        chk("rst_pc", issue_pc, 0);
        chk("rst_mask", issue_mask, 0);
        rst_n = 1;
        cycle();

        set_warp(0, 1, 3'd1, 0, 'h100);
        cycle();
        chk("first_valid", issue_valid, 1);
        chk("first_id", issue_warp_id, 0);
        chk("first_pc", issue_pc, 'h100);

        // GTO greedy run and cap
        gto_ages();
        issue_ready = 1;
        do_flush();
        run_fires(18);
        if (fired.size() >= 18) begin
            for (int i = 0; i < 16; i++) chk("gto_greedy_id", fired[i], 1);
            chk("gto_cap_id", fired[16], 3);
            chk("gto_restart_id", fired[17], 3);
        end

        // LRR rotation, then with warp 2 stalled
        sched_mode = 2'd1;
        do_flush();
        run_fires(5);
        warp_stall = 4'b0100;
        run_fires(8);
        exp_q = '{0, 1, 2, 3, 0, 1, 3, 0};
        if (fired.size() >= 8)
            for (int i = 0; i < 8; i++) chk("lrr_id", fired[i], exp_q[i]);
        warp_stall = 0;

        // Held selection under backpressure, then going stale
        sched_mode = 2'd0;
        issue_ready = 0;
        do_flush();
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", issue_valid, 1);
            chk("hold_id", issue_warp_id, 1);
            cycle();
        end
        ctx_status[1*3 +: 3] = 3'd3;
        #1;
        chk("stale_drop", issue_valid, 0);
        cycle();
        chk("stale_new_valid", issue_valid, 1);
        chk("stale_new_id", issue_warp_id, 3);

        for (int i = 0; i < 8; i++) begin
            ctx_valid = vecs[i].valid;
            ctx_status = vecs[i].status;
            warp_stall = vecs[i].stall;
            cycle();
            cycle();
            chk("tbl_all_done", all_done, vecs[i].exp_done);
            chk("tbl_issue_valid", issue_valid, vecs[i].exp_any);
        end
        warp_stall = 0;

        // Flush with a fire in flight drops greedy preference
        gto_ages();
        issue_ready = 1;
        do_flush();
        repeat (4) cycle();
        ctx_age[0 +: AW] = 8'd20;
        repeat (2) cycle();
        chk("pre_flush_id", issue_warp_id, 1);
        chk("pre_flush_valid", issue_valid, 1);
        flush = 1;
        cycle();
        flush = 0;
        chk("flush_valid", issue_valid, 0);
        cycle();
        chk("post_flush_valid", issue_valid, 1);
        chk("post_flush_id", issue_warp_id, 0);

        // Asynchronous reset during a held handshake
        issue_ready = 0;
        cycle();
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_valid", issue_valid, 0);
        chk("async_rst_id", issue_warp_id, 0);
        @(negedge clk);
        rst_n = 1;
        m_reset();
        cycle();

        for (int s = 0; s < 12; s++) begin
            sched_mode = 2'($urandom_range(0, 3));
            for (int w = 0; w < N; w++)
                set_warp(w, $urandom_range(0, 9) != 0,
                         ($urandom_range(0, 3) != 0) ? 3'd1 : 3'($urandom_range(0, 5)),
                         $urandom_range(0, 3), $urandom);
            for (int c = 0; c < 40; c++) begin
                for (int w = 0; w < N; w++) begin
                    warp_stall[w] = $urandom_range(0, 9) == 0;
                    if ($urandom_range(0, 19) == 0)
                        ctx_status[w*3 +: 3] = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'($urandom_range(0, 5));
                    ctx_pc[w*DW +: DW] = $urandom;
                    ctx_mask[w*WS +: WS] = $urandom;
                end
                issue_ready = $urandom_range(0, 3) != 0;
                flush = $urandom_range(0, 29) == 0;
                cycle();
            end
        end
        flush = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/warp_scheduler_mp.md
Name: warp_scheduler_mp

Overview:
- Parametrised multi-policy successor to the single-policy GTO warp scheduler. Sits between the per-warp context array and the fetch/issue stage of each core.
- Each cycle it picks one eligible warp under a runtime-selectable policy: GTO, loose round-robin (LRR), or oldest-first.
- The pick is presented through a registered valid/ready issue port. A greedy-run cap bounds how long one warp can monopolise issue.

Parameters:
- NUM_WARPS, WARPS_PER_CORE, number of warp contexts (>=2, power of two not required).
- AGE_WIDTH, 8, width of per-warp age inputs.
- MAX_GREEDY, 16, consecutive issues of one warp before forced yield (>=1).
- GREEDY_CNT_W, $clog2(MAX_GREEDY+1), width of the greedy-run counter.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset. Asynchronous, active-low.
- flush, input, 1, synchronous drop of the held selection and greedy/RR state.
- sched_mode, input, 2, scheduling policy: 0 GTO, 1 LRR, 2 oldest-first, 3 treated as GTO.
- ctx_pc, input, NUM_WARPS x DATA_WIDTH, per-warp PC.
- ctx_mask, input, NUM_WARPS x WARP_SIZE, per-warp active mask.
- ctx_status, input, NUM_WARPS x 3, per-warp status (pkg_opengpu warp status enum).
- ctx_age, input, NUM_WARPS x AGE_WIDTH, per-warp age; larger means older.
- ctx_valid, input, NUM_WARPS, context allocated.
- warp_stall, input, NUM_WARPS, per-warp stall (scoreboard/structural).
- issue_valid, output, 1, held selection is valid and still eligible.
- issue_ready, input, 1, downstream accepts the selection.
- issue_warp_id, output, WARP_ID_WIDTH, selected warp.
- issue_pc, output, DATA_WIDTH, selected warp PC, sampled from ctx_pc live.
- issue_mask, output, WARP_SIZE, selected warp mask, sampled from ctx_mask live.
- all_done, output, 1, every valid context is WARP_DONE; also 1 when none are valid.

Behaviour:
- Eligibility: eligible[w] = ctx_valid[w] && ctx_status[w]==WARP_READY && !warp_stall[w]. Mask contents are ignored.
- State registers:
  - sel_valid_q, sel_id_q: held selection.
  - last_id_q, last_valid_q: last issued warp.
  - greedy_cnt_q: saturating at MAX_GREEDY.
- Reset values: all state registers 0; issue_valid=0; issue_warp_id=0.
- issue_pc and issue_mask are combinational from ctx_*[sel_id_q], so they are 0 after reset with zeroed contexts.
- issue_valid = sel_valid_q && eligible[sel_id_q], combinational qualifier. A selection that goes stale drops issue_valid in the same cycle.
- fire = issue_valid && issue_ready.
- Selection register load, when !sel_valid_q || fire || !eligible[sel_id_q]:
  - sel_valid_q <= any(candidate); sel_id_q <= candidate.
  - Otherwise it holds. The id is stable while valid && !ready.
- Latency: a warp becoming eligible from idle shows issue_valid one cycle later. Back-to-back fires are allowed, one per cycle.
- On fire:
  - last_id_q <= sel_id_q; last_valid_q <= 1.
  - greedy_cnt_q <= (sel_id_q==last_id_q && last_valid_q) ? sat(greedy_cnt_q+1) : 1.
- Candidate, computed from the eligible vector with the pending fire's update applied:
  - GTO: if the last warp is eligible and greedy_cnt < MAX_GREEDY, pick it. Otherwise pick the oldest eligible.
  - Oldest-first: the oldest eligible, with no greedy preference.
  - LRR: the first eligible scanning from last_id+1 upward, wrapping modulo NUM_WARPS. With no last_valid, the scan starts at 0.
- Greedy cap: when greedy_cnt==MAX_GREEDY, the last warp is excluded if any other warp is eligible. If it is the sole eligible warp it is still picked and the counter stays saturated.
- Age tie-break: equal ages resolve to the lowest warp id.
- Mode change: takes effect on the next selection load. A held valid selection is not revoked.
- flush (synchronous, highest priority after reset):
  - sel_valid_q, last_valid_q, greedy_cnt_q <= 0.
  - issue_valid=0 in the next cycle.
  - A fire in the same cycle as flush is still accepted downstream but updates no state.
- Asynchronous reset mid-handshake: issue_valid falls immediately.
- all_done is purely combinational.

Decomposition:
- pkg_opengpu gains:
  - sched_mode_e (SCHED_GTO=0, SCHED_LRR=1, SCHED_OLDEST=2).
  - SCHED_MAX_GREEDY default constant.
  - Existing warp status enum, DATA_WIDTH, WARP_SIZE, WARP_ID_WIDTH, WARPS_PER_CORE.
- One sub-module, warp_age_arbiter: combinational oldest-eligible finder over NUM_WARPS with lowest-id tie-break, outputs found and id. Shared by GTO and oldest-first.

Test Plan:
- Reset, no valid contexts -> issue_valid=0, all_done=1. Warp0 READY, age 0, PC 0x100 -> next cycle issue_valid=1, id 0, issue_pc=0x100.
- GTO, ages {5,10,3,7}, ready held high -> first fire id 1, then id 1 repeats for 16 fires. The 17th pick is id 3 (age 7), and greedy_cnt restarts at 1.
- LRR, all 4 ready, ready high -> issue ids 0,1,2,3,0. Stall warp 2 -> ids 1,3,0.
- Handshake: ready=0 for 3 cycles -> id stable. Set warp 1 WAITING while held -> issue_valid drops the same cycle and a new id appears the next cycle.
- Stall mask 4'b1111 -> issue_valid=0. All statuses DONE -> all_done=1. One warp BLOCKED, others DONE -> all_done=0.
- flush asserted with ready=1 -> next cycle issue_valid=0. GTO then picks the oldest rather than the prior greedy warp.
